// File: rtl/pid_pkg.sv
// Shared tuning-register map, reset defaults and packet constants for the UART gain path.
// Reset defaults live here so the hard-wired PID constants and the register resets cannot drift apart.
package pid_pkg;

  localparam logic [7:0] PKT_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    ADDR_K_P_TACH          = 3'd0,
    ADDR_K_I_TACH          = 3'd1,
    ADDR_K_D_TACH          = 3'd2,
    ADDR_K_P_WALL          = 3'd3,
    ADDR_K_I_WALL          = 3'd4,
    ADDR_K_D_WALL          = 3'd5,
    ADDR_DISTANCE_SETPOINT = 3'd6,
    ADDR_BASE_RPM          = 3'd7
  } gain_addr_t;

  typedef enum logic [2:0] {
    WAIT_HDR,
    GET_ADDR,
    GET_HI,
    GET_LO,
    GET_CSUM
  } parse_state_t;

  localparam logic [15:0] DEF_K_P_TACH          = 16'h0F00;
  localparam logic [15:0] DEF_K_I_TACH          = 16'h0000;
  localparam logic [15:0] DEF_K_D_TACH          = 16'h0000;
  localparam logic [15:0] DEF_K_P_WALL          = 16'h0040;
  localparam logic [15:0] DEF_K_I_WALL          = 16'h0000;
  localparam logic [15:0] DEF_K_D_WALL          = 16'h0000;
  localparam logic [6:0]  DEF_DISTANCE_SETPOINT = 7'd20;
  localparam logic [9:0]  DEF_BASE_RPM          = 10'd100;

  function automatic logic [7:0] pkt_csum(input logic [7:0] hdr, input logic [7:0] addr,
                                          input logic [7:0] hi, input logic [7:0] lo);
    return hdr ^ addr ^ hi ^ lo;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: rx_valid/rx_frame_err pulse one cycle after the mid-stop-bit sample (~9.5 bits + sync).
// No backpressure: each byte is presented for one cycle only and must be consumed immediately.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     state, state_d;
  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic          tick;

  // rx_s3 only serves edge detection; rx_s2 is the synchronised line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= serial_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_comb begin
    state_d = state;
    tick    = (state == RX_START) ? (clk_cnt == HALF_LAST) : (clk_cnt == BIT_LAST);
    case (state)
      RX_IDLE:  if (rx_s3 && !rx_s2) state_d = RX_START;
      RX_START: if (tick) state_d = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_cnt      <= '0;
      bit_idx      <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= (state == RX_STOP) && tick && rx_s2;
      rx_frame_err <= (state == RX_STOP) && tick && !rx_s2;
      if (state == RX_IDLE || tick) clk_cnt <= '0;
      else                          clk_cnt <= clk_cnt + 1'b1;
      if (state == RX_START) begin
        bit_idx <= '0;
      end else if (state == RX_DATA && tick) begin
        bit_idx <= bit_idx + 1'b1;
        rx_byte <= {rx_s2, rx_byte[7:1]};
      end
    end
  end

endmodule

// File: rtl/uart_gain_cmd_rx.sv
// Parses HEADER/ADDR/HI/LO/CSUM packets from uart_rx into eight tuning registers; write + cmd_ok one cycle after CSUM rx_valid.
// No backpressure: the host paces bytes; a stalled packet is dropped after TIMEOUT_CLKS idle clocks.
module uart_gain_cmd_rx
  import pid_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 1085,
  parameter int         TIMEOUT_CLKS = 1_250_000,
  parameter logic [7:0] HEADER       = PKT_HEADER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_rx,
  output logic [15:0] k_p_tach,
  output logic [15:0] k_i_tach,
  output logic [15:0] k_d_tach,
  output logic [15:0] k_p_wall,
  output logic [15:0] k_i_wall,
  output logic [15:0] k_d_wall,
  output logic [6:0]  distance_setpoint,
  output logic [9:0]  base_rpm,
  output logic        cmd_ok,
  output logic        cmd_err
);

  localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CLKS);

  logic [7:0]   rx_byte;
  logic         rx_valid, rx_frame_err;
  parse_state_t state, state_d;
  logic [7:0]   addr_q, hi_q, lo_q;
  logic [TW-1:0] to_cnt;
  logic         timeout, abort, wr_en, err_d;
  logic [15:0]  wr_data;
  gain_addr_t   wr_addr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .clk          (clk),
    .reset        (reset),
    .serial_rx    (serial_rx),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  assign timeout = (state != WAIT_HDR) && (to_cnt == TO_LIMIT);
  assign abort   = rx_frame_err || timeout;
  assign wr_data = {hi_q, lo_q};
  assign wr_addr = gain_addr_t'(addr_q[2:0]);

  // Aborts win over a same-cycle byte so a frame error and timeout give a single cmd_err.
  always_comb begin
    state_d = state;
    wr_en   = 1'b0;
    err_d   = 1'b0;
    if (abort) begin
      state_d = WAIT_HDR;
      err_d   = (state != WAIT_HDR);
    end else if (rx_valid) begin
      case (state)
        WAIT_HDR: if (rx_byte == HEADER) state_d = GET_ADDR;
        GET_ADDR: state_d = GET_HI;
        GET_HI:   state_d = GET_LO;
        GET_LO:   state_d = GET_CSUM;
        GET_CSUM: begin
          state_d = WAIT_HDR;
          if (rx_byte == pkt_csum(HEADER, addr_q, hi_q, lo_q) && addr_q[7:3] == 5'd0) wr_en = 1'b1;
          else                                                                      err_d = 1'b1;
        end
        default: state_d = WAIT_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_HDR;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
      addr_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (rx_valid || state == WAIT_HDR) to_cnt <= '0;
      else if (to_cnt != TO_LIMIT)       to_cnt <= to_cnt + 1'b1;
      if (rx_valid) begin
        if (state == GET_ADDR) addr_q <= rx_byte;
        if (state == GET_HI)   hi_q   <= rx_byte;
        if (state == GET_LO)   lo_q   <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_p_tach          <= DEF_K_P_TACH;
      k_i_tach          <= DEF_K_I_TACH;
      k_d_tach          <= DEF_K_D_TACH;
      k_p_wall          <= DEF_K_P_WALL;
      k_i_wall          <= DEF_K_I_WALL;
      k_d_wall          <= DEF_K_D_WALL;
      distance_setpoint <= DEF_DISTANCE_SETPOINT;
      base_rpm          <= DEF_BASE_RPM;
      cmd_ok            <= 1'b0;
      cmd_err           <= 1'b0;
    end else begin
      cmd_ok  <= wr_en;
      cmd_err <= err_d;
      if (wr_en) begin
        case (wr_addr)
          ADDR_K_P_TACH:          k_p_tach          <= wr_data;
          ADDR_K_I_TACH:          k_i_tach          <= wr_data;
          ADDR_K_D_TACH:          k_d_tach          <= wr_data;
          ADDR_K_P_WALL:          k_p_wall          <= wr_data;
          ADDR_K_I_WALL:          k_i_wall          <= wr_data;
          ADDR_K_D_WALL:          k_d_wall          <= wr_data;
          ADDR_DISTANCE_SETPOINT: distance_setpoint <= wr_data[6:0];
          ADDR_BASE_RPM:          base_rpm          <= wr_data[9:0];
          default:                ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_gain_cmd_rx.sv
// Scoreboarded bench for uart_gain_cmd_rx: serial packets in, cmd_ok/cmd_err events and register file checked.
module tb_uart_gain_cmd_rx;

  localparam int CPB = 16;
  localparam int TO  = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        serial_rx;
  logic [15:0] k_p_tach, k_i_tach, k_d_tach, k_p_wall, k_i_wall, k_d_wall;
  logic [6:0]  distance_setpoint;
  logic [9:0]  base_rpm;
  logic        cmd_ok, cmd_err;

  uart_gain_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO), .HEADER(8'hA5)) dut (
    .clk               (clk),
    .reset             (reset),
    .serial_rx         (serial_rx),
    .k_p_tach          (k_p_tach),
    .k_i_tach          (k_i_tach),
    .k_d_tach          (k_d_tach),
    .k_p_wall          (k_p_wall),
    .k_i_wall          (k_i_wall),
    .k_d_wall          (k_d_wall),
    .distance_setpoint (distance_setpoint),
    .base_rpm          (base_rpm),
    .cmd_ok            (cmd_ok),
    .cmd_err           (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_ok;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] mdl [8];
  int          pass_cnt = 0;
  int          chk_cnt = 0;
  int          cyc = 0;
  int          stop_start_cyc = 0;
  int          last_ok_lat = -1;
  int          last_evt_cyc = 0;
  logic [112:0] dut_regs;

  assign dut_regs = {k_p_tach, k_i_tach, k_d_tach, k_p_wall, k_i_wall, k_d_wall,
                     distance_setpoint, base_rpm};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [112:0] mdl_regs();
    return {mdl[0], mdl[1], mdl[2], mdl[3], mdl[4], mdl[5], mdl[6][6:0], mdl[7][9:0]};
  endfunction

  function automatic logic [7:0] bench_csum(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l);
    return 8'hA5 ^ a ^ h ^ l;
  endfunction

  task automatic model_reset();
    mdl[0] = 16'h0F00; mdl[1] = 16'h0000; mdl[2] = 16'h0000; mdl[3] = 16'h0040;
    mdl[4] = 16'h0000; mdl[5] = 16'h0000; mdl[6] = 16'd20;   mdl[7] = 16'd100;
  endtask

  // Every cmd_ok/cmd_err is matched against the scoreboard and the whole register file re-checked.
  always @(negedge clk) begin
    if (!reset && (cmd_ok || cmd_err)) begin
      last_evt_cyc = cyc;
      chk_cnt++;
      if (cmd_ok && cmd_err) begin
        $display("FAIL pulse_overlap: cmd_ok=%b cmd_err=%b, required never both high", cmd_ok, cmd_err);
      end else if (sb_q.size() == 0) begin
        $display("FAIL unexpected_event: cmd_ok=%b cmd_err=%b, required no event", cmd_ok, cmd_err);
      end else begin
        mon_e = sb_q.pop_front();
        if (cmd_ok !== mon_e.is_ok) begin
          $display("FAIL event_kind: cmd_ok=%b cmd_err=%b, required cmd_ok=%b", cmd_ok, cmd_err, mon_e.is_ok);
        end else begin
          pass_cnt++;
          if (cmd_ok) begin
            mdl[mon_e.addr] = mon_e.data;
            last_ok_lat = cyc - stop_start_cyc;
          end
          chk_cnt++;
          if (dut_regs !== mdl_regs())
            $display("FAIL regfile: got %h, required %h", dut_regs, mdl_regs());
          else
            pass_cnt++;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge ending the stop bit, so calls chain with no idle gap.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    serial_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    stop_start_cyc = cyc;
    serial_rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_packet(input logic [7:0] addr, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] csum);
    exp_t e;
    e.is_ok = (csum == bench_csum(addr, hi, lo)) && (addr <= 8'd7);
    e.addr  = addr[2:0];
    e.data  = {hi, lo};
    sb_q.push_back(e);
    send_byte(8'hA5);
    send_byte(addr);
    send_byte(hi);
    send_byte(lo);
    send_byte(csum);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && sb_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    serial_rx = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (dut_regs !== mdl_regs()) $display("FAIL reset_regs: got %h, required %h", dut_regs, mdl_regs());
    else pass_cnt++;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk_cnt++;
    if ({cmd_ok, cmd_err} !== 2'b00) $display("FAIL reset_pulses: got %b, required 00", {cmd_ok, cmd_err});
    else pass_cnt++;
    chk_cnt++;
    if (dut_regs !== mdl_regs()) $display("FAIL post_reset_regs: got %h, required %h", dut_regs, mdl_regs());
    else pass_cnt++;
  endtask

  task automatic test_valid_write();
    last_ok_lat = -1;
    send_packet(8'h00, 8'h12, 8'h34, bench_csum(8'h00, 8'h12, 8'h34));
    wait_drain(4 * CPB);
    chk_cnt++;
    if (sb_q.size() != 0) $display("FAIL valid_event_missing: pending %0d, required 0", sb_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (k_p_tach !== 16'h1234) $display("FAIL valid_k_p_tach: got %h, required 1234", k_p_tach);
    else pass_cnt++;
    chk_cnt++;
    if (last_ok_lat < CPB / 2 || last_ok_lat > CPB / 2 + 8)
      $display("FAIL valid_latency: got %0d cycles after stop start, required %0d..%0d", last_ok_lat, CPB / 2, CPB / 2 + 8);
    else pass_cnt++;
  endtask

  task automatic test_bad_checksum();
    send_packet(8'h03, 8'h00, 8'h80, 8'h00);
    wait_drain(4 * CPB);
    chk_cnt++;
    if (sb_q.size() != 0) $display("FAIL badcsum_event_missing: pending %0d, required 0", sb_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (k_p_wall !== 16'h0040) $display("FAIL badcsum_k_p_wall: got %h, required 0040", k_p_wall);
    else pass_cnt++;
  endtask

  task automatic test_bad_addr();
    send_packet(8'h09, 8'h00, 8'h01, 8'hAD);
    wait_drain(4 * CPB);
    chk_cnt++;
    if (sb_q.size() != 0) $display("FAIL badaddr_event_missing: pending %0d, required 0", sb_q.size());
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    exp_t e;
    int   t0;
    e = '0;
    sb_q.push_back(e);
    send_byte(8'hA5);
    send_byte(8'h06);
    t0 = cyc;
    for (int i = 0; i < TO + 400 && sb_q.size() != 0; i++) @(negedge clk);
    chk_cnt++;
    if (sb_q.size() != 0) $display("FAIL timeout_event_missing: pending %0d, required 0", sb_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (last_evt_cyc - t0 < TO - 40 || last_evt_cyc - t0 > TO + 20)
      $display("FAIL timeout_delay: got %0d cycles, required about %0d", last_evt_cyc - t0, TO);
    else pass_cnt++;
    send_packet(8'h06, 8'h00, 8'h1E, 8'hBD);
    wait_drain(4 * CPB);
    chk_cnt++;
    if (distance_setpoint !== 7'd30) $display("FAIL timeout_distance: got %0d, required 30", distance_setpoint);
    else pass_cnt++;
  endtask

  task automatic test_framing();
    exp_t e;
    e = '0;
    sb_q.push_back(e);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h12, 1'b0);
    serial_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk_cnt++;
    if (sb_q.size() != 0) $display("FAIL frame_event_missing: pending %0d, required 0", sb_q.size());
    else pass_cnt++;
    // A framing error while waiting for a header, then garbage, must stay silent.
    send_byte(8'h33, 1'b0);
    serial_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_packet(8'h04, 8'h00, 8'h55, bench_csum(8'h04, 8'h00, 8'h55));
    wait_drain(4 * CPB);
    chk_cnt++;
    if (k_i_wall !== 16'h0055) $display("FAIL frame_resync_k_i_wall: got %h, required 0055", k_i_wall);
    else pass_cnt++;
    chk_cnt++;
    if (sb_q.size() != 0) $display("FAIL frame_resync_event: pending %0d, required 0", sb_q.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    send_packet(8'h07, 8'h00, 8'hC8, bench_csum(8'h07, 8'h00, 8'hC8));
    send_packet(8'h01, 8'h01, 8'h23, bench_csum(8'h01, 8'h01, 8'h23));
    wait_drain(4 * CPB);
    chk_cnt++;
    if (base_rpm !== 10'd200) $display("FAIL b2b_base_rpm: got %0d, required 200", base_rpm);
    else pass_cnt++;
    chk_cnt++;
    if (k_i_tach !== 16'h0123) $display("FAIL b2b_k_i_tach: got %h, required 0123", k_i_tach);
    else pass_cnt++;
    chk_cnt++;
    if (sb_q.size() != 0) $display("FAIL b2b_events: pending %0d, required 0", sb_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_packet();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h12);
    serial_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (dut_regs !== mdl_regs()) $display("FAIL midreset_regs: got %h, required %h", dut_regs, mdl_regs());
    else pass_cnt++;
    serial_rx = 1'b1;
    reset = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    chk_cnt++;
    if (base_rpm !== 10'd100) $display("FAIL midreset_base_rpm: got %0d, required 100", base_rpm);
    else pass_cnt++;
    send_packet(8'h02, 8'h00, 8'h42, bench_csum(8'h02, 8'h00, 8'h42));
    wait_drain(4 * CPB);
    chk_cnt++;
    if (k_d_tach !== 16'h0042) $display("FAIL midreset_k_d_tach: got %h, required 0042", k_d_tach);
    else pass_cnt++;
    chk_cnt++;
    if (sb_q.size() != 0) $display("FAIL midreset_events: pending %0d, required 0", sb_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_valid_write();
    test_bad_checksum();
    test_bad_addr();
    test_timeout();
    test_framing();
    test_back_to_back();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation still running after 200000 cycles, required completion");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
